// File: rtl/logic_unit_pipe_if.sv
// Beat/result handshake bundle for logic_unit_pipe.
// master: drives beats and out_ready; slave: the pipe itself.
interface logic_unit_pipe_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] y;
   logic [CNT_W-1:0] y_cnt;

   modport master (
      output in_valid, op, a, b, in_last, out_ready,
      input  in_ready, out_valid, y, y_cnt
   );

   modport slave (
      input  in_valid, op, a, b, in_last, out_ready,
      output in_ready, out_valid, y, y_cnt
   );
endinterface

// File: rtl/logic_unit_pipe.sv
// Bitwise logic unit with AND/OR packet accumulator, one output register.
// Ports: clk, rst (async, active-high), bus (slave: beats in, results out).
module logic_unit_pipe #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input logic            clk,
   input logic            rst,
   logic_unit_pipe_if.slave bus
);

   typedef enum logic {IDLE, ACC} state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [2:0]       acc_op_q, acc_op_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic [CNT_W-1:0] y_cnt_q, y_cnt_d;

   logic             in_ready;
   logic             accept;
   logic             is_acc_op;
   logic [WIDTH-1:0] logic_res;
   logic [WIDTH-1:0] fold;
   logic [CNT_W-1:0] cnt_inc;

   // Output slot is free when empty or draining this cycle.
   assign in_ready  = !out_valid_q || bus.out_ready;
   assign accept    = bus.in_valid && in_ready;
   assign is_acc_op = bus.op[2] && bus.op[1];

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.y         = y_q;
   assign bus.y_cnt     = y_cnt_q;

   always_comb begin
      logic_res = '0;
      unique case (bus.op)
         3'd0: logic_res = bus.a & bus.b;
         3'd1: logic_res = bus.a | bus.b;
         3'd2: logic_res = bus.a ^ bus.b;
         3'd3: logic_res = ~(bus.a & bus.b);
         3'd4: logic_res = ~(bus.a | bus.b);
         3'd5: logic_res = ~(bus.a ^ bus.b);
         default: logic_res = '0;
      endcase
   end

   // Packet op is fixed by the first beat; bit 0 picks OR over AND.
   assign fold = acc_op_q[0] ? (acc_q | bus.a) : (acc_q & bus.a);

   // Beat count sticks at all-ones instead of wrapping.
   assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (accept) begin
         unique case (state_q)
            IDLE: if (is_acc_op && !bus.in_last) state_d = ACC;
            ACC:  if (bus.in_last) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      out_valid_d = out_valid_q && !bus.out_ready;
      y_d         = y_q;
      y_cnt_d     = y_cnt_q;
      acc_d       = acc_q;
      acc_op_d    = acc_op_q;
      cnt_d       = cnt_q;
      if (accept) begin
         unique case (state_q)
            IDLE: begin
               if (!is_acc_op) begin
                  y_d         = logic_res;
                  y_cnt_d     = CNT_ONE;
                  out_valid_d = 1'b1;
               end else if (bus.in_last) begin
                  y_d         = bus.a;
                  y_cnt_d     = CNT_ONE;
                  out_valid_d = 1'b1;
               end else begin
                  acc_d    = bus.a;
                  acc_op_d = bus.op;
                  cnt_d    = CNT_ONE;
               end
            end
            ACC: begin
               if (bus.in_last) begin
                  y_d         = fold;
                  y_cnt_d     = cnt_inc;
                  out_valid_d = 1'b1;
               end else begin
                  acc_d = fold;
                  cnt_d = cnt_inc;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q       <= '0;
         acc_op_q    <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         y_q         <= '0;
         y_cnt_q     <= '0;
      end else begin
         acc_q       <= acc_d;
         acc_op_q    <= acc_op_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         y_q         <= y_d;
         y_cnt_q     <= y_cnt_d;
      end
   end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: random and directed beats
// against a packet-level reference model.
module tb_logic_unit_pipe;

   localparam int CMAX = 15;

   typedef struct {
      logic [7:0] y;
      logic [3:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   logic_unit_pipe_if #(.WIDTH(8), .CNT_W(4)) bus ();
   logic_unit_pipe_if #(.WIDTH(8), .CNT_W(2)) bus2 ();

   logic_unit_pipe #(.WIDTH(8), .CNT_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   logic_unit_pipe #(.WIDTH(8), .CNT_W(2)) dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2.slave)
   );

   int   n_checks = 0;
   int   n_pass   = 0;
   exp_t exp_q[$];

   bit   rdy_rand  = 1'b0;
   bit   rdy_fixed = 1'b1;

   // reference model state: open packet kept as a list of operands
   bit         m_open = 1'b0;
   logic [2:0] m_op;
   logic [7:0] m_pkt[$];

   task automatic check(input string name, input logic [63:0] got,
                        input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   function automatic logic [7:0] ref_bitwise(input logic [2:0] op,
                                              input logic [7:0] a,
                                              input logic [7:0] b);
      case (op)
         3'd0: return a & b;
         3'd1: return a | b;
         3'd2: return a ^ b;
         3'd3: return ~(a & b);
         3'd4: return ~(a | b);
         default: return ~(a ^ b);
      endcase
   endfunction

   task automatic model_beat(input logic [2:0] op, input logic [7:0] a,
                             input logic [7:0] b, input bit last);
      exp_t       e;
      logic [7:0] r;
      int         n;
      if (!m_open && op < 3'd6) begin
         e.y = ref_bitwise(op, a, b);
         e.cnt = 4'd1;
         exp_q.push_back(e);
      end else if (!m_open) begin
         m_op = op;
         m_pkt.delete();
         m_pkt.push_back(a);
         if (last) begin
            e.y = a;
            e.cnt = 4'd1;
            exp_q.push_back(e);
         end else begin
            m_open = 1'b1;
         end
      end else begin
         m_pkt.push_back(a);
         if (last) begin
            r = m_pkt[0];
            foreach (m_pkt[i]) r = (m_op == 3'd6) ? (r & m_pkt[i]) : (r | m_pkt[i]);
            n = m_pkt.size();
            e.y = r;
            e.cnt = 4'((n > CMAX) ? CMAX : n);
            exp_q.push_back(e);
            m_open = 1'b0;
         end
      end
   endtask

   // Offer one beat; returns 1 ns after the edge that accepts it.
   task automatic send(input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input bit last);
      int guard;
      guard = 0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.op       = op;
      bus.a        = a;
      bus.b        = b;
      bus.in_last  = last;
      forever begin
         #1;
         if (bus.in_ready) break;
         guard++;
         if (guard > 200) begin
            check("accept_timeout", 0, 1);
            bus.in_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      model_beat(op, a, b, last);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   always @(negedge clk)
      bus.out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_fixed;

   // Monitor: a transfer happens at the next edge when valid && ready.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               check("sb_unexpected_out", {56'd0, bus.y}, 64'hdead);
            end else begin
               e = exp_q.pop_front();
               check("sb_y", bus.y, e.y);
               check("sb_cnt", bus.y_cnt, e.cnt);
            end
         end
      end
   end

   logic [7:0] dir_exp[6];
   logic [7:0] held;

   initial begin
      bus.in_valid = 1'b0;
      bus.op = '0;
      bus.a = '0;
      bus.b = '0;
      bus.in_last = 1'b0;
      bus.out_ready = 1'b1;
      bus2.in_valid = 1'b0;
      bus2.op = '0;
      bus2.a = '0;
      bus2.b = '0;
      bus2.in_last = 1'b0;
      bus2.out_ready = 1'b1;

      #3;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_y", bus.y, 0);
      check("rst_y_cnt", bus.y_cnt, 0);
      check("rst_in_ready", bus.in_ready, 1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", bus.in_ready, 1);

      // bitwise ops, latency one cycle
      dir_exp[0] = 8'hC0; dir_exp[1] = 8'hFC; dir_exp[2] = 8'h3C;
      dir_exp[3] = 8'h3F; dir_exp[4] = 8'h03; dir_exp[5] = 8'hC3;
      for (int i = 0; i < 6; i++) begin
         send(3'(i), 8'hF0, 8'hCC, 1'b0);
         check("op_valid", bus.out_valid, 1);
         check("op_y", bus.y, dir_exp[i]);
         check("op_cnt", bus.y_cnt, 1);
      end

      // ACC_AND packet
      send(3'd6, 8'hFF, 8'h00, 1'b0);
      check("and_beat1_novalid", bus.out_valid, 0);
      send(3'd6, 8'hF7, 8'h00, 1'b0);
      check("and_beat2_novalid", bus.out_valid, 0);
      send(3'd6, 8'h7F, 8'h00, 1'b1);
      check("and_valid", bus.out_valid, 1);
      check("and_y", bus.y, 8'h77);
      check("and_cnt", bus.y_cnt, 3);

      // ACC_OR packet, later op fields ignored
      send(3'd7, 8'h01, 8'h00, 1'b0);
      check("or_beat1_novalid", bus.out_valid, 0);
      send(3'd0, 8'h02, 8'hFF, 1'b0);
      send(3'd0, 8'h80, 8'hFF, 1'b1);
      check("or_y", bus.y, 8'h83);
      check("or_cnt", bus.y_cnt, 3);

      // output stall, then release into back-to-back results
      repeat (2) @(posedge clk);
      #1;
      rdy_fixed = 1'b0;
      send(3'd0, 8'hF0, 8'hCC, 1'b0);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.op = 3'd1;
      bus.a = 8'hF0;
      bus.b = 8'hCC;
      bus.in_last = 1'b0;
      #1;
      held = bus.y;
      check("stall_y", held, 8'hC0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         check("stall_in_ready", bus.in_ready, 0);
         check("stall_valid", bus.out_valid, 1);
         check("stall_hold_y", bus.y, held);
      end
      #2;
      rdy_fixed = 1'b1;
      send(3'd1, 8'hF0, 8'hCC, 1'b0);
      check("b2b_valid1", bus.out_valid, 1);
      check("b2b_y1", bus.y, 8'hFC);
      send(3'd2, 8'hF0, 8'hCC, 1'b0);
      check("b2b_valid2", bus.out_valid, 1);
      check("b2b_y2", bus.y, 8'h3C);

      // reset in the middle of an OR packet
      send(3'd7, 8'h11, 8'h00, 1'b0);
      send(3'd7, 8'h22, 8'h00, 1'b0);
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("mid_rst_valid", bus.out_valid, 0);
      check("mid_rst_y", bus.y, 0);
      check("mid_rst_cnt", bus.y_cnt, 0);
      check("mid_rst_in_ready", bus.in_ready, 1);
      m_open = 1'b0;
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      send(3'd0, 8'hFF, 8'h0F, 1'b0);
      check("after_rst_y", bus.y, 8'h0F);
      check("after_rst_cnt", bus.y_cnt, 1);

      // saturating count on the narrow-counter instance
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         bus2.in_valid = 1'b1;
         bus2.op = 3'd6;
         bus2.a = 8'hFF;
         bus2.in_last = (i == 5);
         #1;
         check("sat_in_ready", bus2.in_ready, 1);
         check("sat_no_early_valid", bus2.out_valid, 0);
         @(posedge clk);
         #1;
         bus2.in_valid = 1'b0;
      end
      check("sat_valid", bus2.out_valid, 1);
      check("sat_y", bus2.y, 8'hFF);
      check("sat_cnt", bus2.y_cnt, 3);

      // random traffic with random backpressure, long packets included
      rdy_rand = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 5) == 0) @(posedge clk);
         send(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
              ($urandom_range(0, 5) == 0));
      end
      send(3'd7, 8'h00, 8'h00, 1'b1);
      rdy_rand = 1'b0;
      rdy_fixed = 1'b1;
      repeat (6) @(negedge clk);
      #3;
      check("sb_drained", exp_q.size(), 0);
      check("final_valid", bus.out_valid, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
